// File: rtl/hamming_inject_sequencer.sv
// Self-test sequencer for the Hamming(7,4) encode -> inject -> decode chain.
// Sweeps every nibble against error positions 0..POS_MAX, SETTLE_CYCLES+1 cycles per vector.
// Optional first-failure log: define HAMMING_SEQ_ERR_LOG_EN to build fail_data/fail_pos/fail_valid.
module hamming_inject_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int POS_MAX       = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] data_out,
  output logic [2:0] error_pos,
  input  logic [3:0] dec_data,
  input  logic [2:0] dec_syndrome,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [3:0] fail_data,
  output logic [2:0] fail_pos,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] POS_LAST    = 3'(POS_MAX);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       vec_pass;
  logic       last_vec;

  // A vector passes when the decoder both restores the nibble and names the flipped bit.
  assign vec_pass = (dec_data == data_out) && (dec_syndrome == error_pos);
  assign last_vec = (data_out == 4'hF) && (error_pos == POS_LAST);

  // Sweep FSM: settle, sample, advance position-then-data; abort beats the count in CHECK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      data_out   <= '0;
      error_pos  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done       <= 1'b0;
          settle_cnt <= '0;
          if (start) begin
            state     <= S_APPLY;
            busy      <= 1'b1;
            data_out  <= '0;
            error_pos <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_APPLY: begin
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= S_CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (vec_pass) pass_cnt <= pass_cnt + 8'd1;
            else          fail_cnt <= fail_cnt + 8'd1;
            if (last_vec) begin
              // Final vector: hold data_out/error_pos for the DONE cycle.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_APPLY;
              if (error_pos == POS_LAST) begin
                error_pos <= '0;
                data_out  <= data_out + 4'd1;
              end else begin
                error_pos <= error_pos + 3'd1;
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAMMING_SEQ_ERR_LOG_EN
  logic start_go;
  logic check_fail;

  assign start_go   = start && ((state == S_IDLE) || (state == S_DONE));
  assign check_fail = (state == S_CHECK) && !abort && !vec_pass;

  // Latch only the first failing vector of a sweep; a new sweep clears the log.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_data  <= '0;
      fail_pos   <= '0;
      fail_valid <= 1'b0;
    end else if (start_go) begin
      fail_data  <= '0;
      fail_pos   <= '0;
      fail_valid <= 1'b0;
    end else if (check_fail && !fail_valid) begin
      fail_data  <= data_out;
      fail_pos   <= error_pos;
      fail_valid <= 1'b1;
    end
  end
`else
  assign fail_data  = '0;
  assign fail_pos   = '0;
  assign fail_valid = 1'b0;
`endif

endmodule
